// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state
// encoding, function-code constants and the function-code decoder.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } seq_state_t;

  localparam logic [3:0] CODE_SUM  = 4'd8;
  localparam logic [3:0] CODE_SUBT = 4'd9;
  localparam logic [3:0] CODE_MAX  = 4'd9;
  localparam logic [2:0] OP_IDLE   = 3'b111;

  typedef struct packed {
    logic       ok;
    logic [2:0] op;
    logic       sum;
    logic       subt;
  } op_decode_t;

  // Logic functions travel to the ALU inverted; add/subtract park the
  // function select at OP_IDLE and raise their own strobe instead.
  function automatic op_decode_t decode_code(input logic [3:0] code);
    op_decode_t d;
    d.ok   = 1'b0;
    d.op   = OP_IDLE;
    d.sum  = 1'b0;
    d.subt = 1'b0;
    if (code <= CODE_MAX) begin
      d.ok = 1'b1;
      if (code == CODE_SUM) begin
        d.sum = 1'b1;
      end else if (code == CODE_SUBT) begin
        d.subt = 1'b1;
      end else begin
        d.op = ~code[2:0];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_btn_conditioner.sv
// Active-low button front end: 2-flop synchronizer, optional debounce
// counter (ALU_SEQ_DEBOUNCE_EN) and a falling-edge one-cycle press pulse.
module btn_conditioner #(
  parameter int DB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  if (DB_CYCLES < 1) begin : g_db_range
    $error("btn_conditioner: DB_CYCLES must be at least 1");
  end

  logic sync_1;
  logic sync_2;
  logic level;
  logic level_q;

  // Reset to the released (high) level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= btn_n;
      sync_2 <= sync_1;
    end
  end

`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_FULL = CW'(DB_CYCLES);

  logic [CW-1:0] db_cnt;

  // Counts consecutive low samples; any high sample restarts it, and it
  // parks at DB_FULL so a held button never wraps into a second press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
    end else if (sync_2) begin
      db_cnt <= '0;
    end else if (db_cnt != DB_FULL) begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

  assign level = (db_cnt != DB_FULL);
`else
  assign level = sync_2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_q <= level;
      press   <= level_q & ~level;
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board-facing controller for the combinational ALU: loads A, B and a function
// code from switches on button presses, then captures the ALU result.
// Build option: ALU_SEQ_DEBOUNCE_EN enables the per-button debounce counter.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N         = 4,
  parameter int DB_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] sw,
  input  logic         btn_next_n,
  input  logic         btn_clr_n,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_op,
  output logic         alu_op_sum,
  output logic         alu_op_subt,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  output logic [N-1:0] result_q,
  output logic         carry_q,
  output logic         valid,
  output logic         err,
  output logic [2:0]   state_o
);

  if (N < 4) begin : g_width_range
    $error("alu_operand_sequencer: N must be at least 4");
  end

  logic       next_press;
  logic       clr_press;
  seq_state_t state;
  op_decode_t dec;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_next_n),
    .press (next_press)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_clr_n),
    .press (clr_press)
  );

  assign dec     = decode_code(sw[3:0]);
  assign state_o = state;

  // valid: rises at the end of EXEC together with result_q/carry_q and stays
  // high while the capture is on display; there is no ready, the consumer
  // simply samples result_q/carry_q whenever valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD_A;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_IDLE;
      alu_op_sum  <= 1'b0;
      alu_op_subt <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      valid       <= 1'b0;
      err         <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr_press) begin
        // Clear overrides any simultaneous next press.
        state       <= LOAD_A;
        alu_a       <= '0;
        alu_b       <= '0;
        alu_op      <= OP_IDLE;
        alu_op_sum  <= 1'b0;
        alu_op_subt <= 1'b0;
        result_q    <= '0;
        carry_q     <= 1'b0;
        valid       <= 1'b0;
      end else begin
        case (state)
          LOAD_A: begin
            if (next_press) begin
              alu_a <= sw;
              state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (next_press) begin
              alu_b <= sw;
              state <= LOAD_OP;
            end
          end
          LOAD_OP: begin
            if (next_press) begin
              if (dec.ok) begin
                alu_op      <= dec.op;
                alu_op_sum  <= dec.sum;
                alu_op_subt <= dec.subt;
                state       <= EXEC;
              end else begin
                err <= 1'b1;
              end
            end
          end
          EXEC: begin
            // ALU inputs were registered on entry, so the result is settled here.
            result_q <= alu_result;
            carry_q  <= alu_carry;
            valid    <= 1'b1;
            state    <= SHOW;
          end
          SHOW: begin
            if (next_press) begin
              valid <= 1'b0;
              state <= LOAD_A;
            end
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end controller that drives the Lab 2 combinational ALU from board switches and active-low push buttons. It debounces the buttons and walks an FSM that loads operand A, operand B and a function code into registers, then presents them to the ALU. It then captures the ALU result and carry into output registers for display. It sits between the board I/O and the ALU, producing exactly the `a`, `b`, `op`, `op_sum`, `op_subt` stimulus the ALU consumes.

## Interface
- `N`, default 4: operand/result width, N ≥ 4
- `DB_CYCLES`, default 16: consecutive stable-low cycles required to accept a button press
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `sw`  in  N  operand / function-code switches, asynchronous to `clk`
- `btn_next_n`  in  1  advance button, active-low (0 = pressed), asynchronous
- `btn_clr_n`  in  1  clear button, active-low, asynchronous
- `alu_a`  out  N  operand A to ALU
- `alu_b`  out  N  operand B to ALU
- `alu_op`  out  3  ALU function select, inverted encoding: `alu_op = ~func`
- `alu_op_sum`  out  1  high selects ALU addition
- `alu_op_subt`  out  1  high selects ALU subtraction
- `alu_result`  in  N  ALU result
- `alu_carry`  in  1  ALU carry/borrow
- `result_q`  out  N  captured result
- `carry_q`  out  1  captured carry
- `valid`  out  1  high while `result_q`/`carry_q` hold a fresh capture
- `err`  out  1  one-cycle pulse on a rejected function code
- `state_o`  out  3  current FSM state, for LEDs

## Operation
- Each button passes through a 2-flop synchronizer, then qualification, then a falling-edge detector. The result is one `press` pulse per physical press.
- FSM states are `LOAD_A`, `LOAD_B`, `LOAD_OP`, `EXEC`, `SHOW`. Reset state is `LOAD_A`.
- `LOAD_A`, on next press: `alu_a <= sw`, go to `LOAD_B`.
- `LOAD_B`, on next press: `alu_b <= sw`, go to `LOAD_OP`.
- `LOAD_OP`, on next press, the code is `sw[3:0]`:
  - Code 0–7: `func = code`, `op_sum = op_subt = 0`.
  - Code 8: `op_sum = 1`, `alu_op = 3'b111`.
  - Code 9: `op_subt = 1`, `alu_op = 3'b111`.
  - Code 10–15: rejected. `err` pulses, state and registers are unchanged.
  - Accepted codes go to `EXEC`.
- `EXEC` lasts exactly one cycle. At its end, `result_q <= alu_result` and `carry_q <= alu_carry`, `valid <= 1`, go to `SHOW`.
- `SHOW`, on next press: `valid <= 0`, go to `LOAD_A`. `alu_a`, `alu_b` and `alu_op` are held until overwritten.
- Clear press, any state: all registers return to reset values and the state goes to `LOAD_A` next cycle.
- Clear and next pressed in the same cycle: clear wins.
- Reset values:
  - `alu_a`, `alu_b`, `result_q` = 0
  - `carry_q`, `valid`, `err`, `alu_op_sum`, `alu_op_subt` = 0
  - `alu_op` = 3'b111
  - `state_o` = `LOAD_A` encoding (0)
- `rst_n` asserted mid-operation clears everything immediately, including synchronizers and debounce counters.
- Holding a button produces no repeat. A new press requires a release, meaning the qualified level returns high.

## Timing
- All ALU-facing outputs are registered. The ALU sees stable inputs for the full `EXEC` cycle.
- Press latency, with debounce: the `press` pulse comes one cycle after the synchronized level has been low for `DB_CYCLES` consecutive cycles. Any high sample restarts the count.
- Press latency, without debounce: `press` comes one cycle after the synchronized level first reads low. This is 3 cycles from a clean falling edge.
- From an accepted `LOAD_OP` press: `EXEC` is the next cycle, `valid` rises the cycle after, and `result_q` is valid in that same cycle.
- `err` is high for exactly one cycle, the cycle after the rejected press.
- The debounce counter saturates at `DB_CYCLES` and does not wrap.

## Configuration
- `ALU_SEQ_DEBOUNCE_EN` defined: a debounce counter of `DB_CYCLES` cycles sits on each button after the synchronizer.
- Not defined: there is no counter, `DB_CYCLES` is ignored, and the edge detector acts directly on the synchronized level, for simulation speed.

## Structure
- Package `alu_seq_pkg`:
  - state enum `seq_state_t`
  - code constants `CODE_SUM = 4'd8`, `CODE_SUBT = 4'd9`, `CODE_MAX = 4'd9`
  - `OP_IDLE = 3'b111`
- Sub-module `btn_conditioner` contains synchronizer, optional debounce and falling-edge pulse. It is instantiated twice, once for next and once for clear.

## Test plan
- Reset, then check: all outputs at reset values, `state_o = 0`, `alu_op = 3'b111`.
- `sw` = 8, press, `sw` = 8, press, `sw` = 3, press → `alu_op = 3'b100`, `op_sum = op_subt = 0`, `valid` rises 2 cycles after the `LOAD_OP` press pulse, and `result_q` matches the ALU model.
- A = 15, B = 8, code 8 → `op_sum = 1`, `alu_op = 3'b111`, `result_q = 7`, `carry_q = 1`.
- A = 15, B = 15, code 9 → `op_subt = 1`, `result_q = 0`.
- In `LOAD_OP`, code 12 → `err` pulses 1 cycle, state stays `LOAD_OP`, and a subsequent code 2 is accepted.
- With `ALU_SEQ_DEBOUNCE_EN`:
  - a 5-cycle bounce train then a steady low of `DB_CYCLES` gives exactly one press.
  - clear and next pressed together in `LOAD_B` → `LOAD_A` with `alu_a = 0`.
  - `rst_n` low during `EXEC` → all outputs at reset values within the same cycle.
